// File: rtl/det_pkg.sv
// rtl/det_pkg.sv - shared types and constants for the determinant result writer
package det_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARMED  = 3'd1,
    WR_LO  = 3'd2,
    WR_HI  = 3'd3,
    FULL   = 3'd4
  } writer_state_t;

endpackage

// File: rtl/counter.sv
// rtl/counter.sv - loadable up-counter, wraps modulo 2^W
module counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         enable,
  output logic [W-1:0] value
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (load) begin
      value <= load_value;
    end else if (enable) begin
      value <= value + W'(1);
    end
  end

endmodule

// File: rtl/determinant_result_writer.sv
// rtl/determinant_result_writer.sv - stores 16-bit results as low/high byte pairs into matrix memory
module determinant_result_writer
  import det_pkg::*;
#(
  parameter int ADDR_W      = 4,
  parameter int RES_W       = 16,
  parameter int MAX_RESULTS = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_adress,
  input  logic              res_valid,
  input  logic [RES_W-1:0]  res_data,
  output logic              res_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_adress,
  output logic [BYTE_W-1:0] mem_data,
  output logic [ADDR_W-1:0] count,
  output logic              full
);

  writer_state_t     state;
  writer_state_t     state_next;
  logic [RES_W-1:0]  hold;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] count_inc;
  logic              ptr_en;
  logic              handshake;

  assign handshake = (state == ARMED) && res_valid && !start;
  assign ptr_en    = ((state == WR_LO) || (state == WR_HI)) && !start;
  assign count_inc = count + ADDR_W'(1);

  counter #(ADDR_W) u_ptr (
    .clk        (clock),
    .rst_n      (reset),
    .load       (start),
    .load_value (start_adress),
    .enable     (ptr_en),
    .value      (ptr)
  );

  // start overrides every state, including a half-finished byte pair
  always_comb begin
    state_next = state;
    if (start) begin
      state_next = ARMED;
    end else begin
      case (state)
        IDLE:    state_next = IDLE;
        ARMED:   if (res_valid) state_next = WR_LO;
        WR_LO:   state_next = WR_HI;
        WR_HI:   state_next = (count_inc == ADDR_W'(MAX_RESULTS)) ? FULL : ARMED;
        FULL:    state_next = FULL;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      hold  <= '0;
      count <= '0;
    end else begin
      state <= state_next;
      if (handshake) begin
        hold <= res_data;
      end
      if (start) begin
        count <= '0;
      end else if (state == WR_HI) begin
        count <= count_inc;
      end
    end
  end

  always_comb begin
    mem_we     = 1'b0;
    mem_data   = '0;
    mem_adress = ptr;
    case (state)
      WR_LO: begin
        mem_we   = 1'b1;
        mem_data = hold[BYTE_W-1:0];
      end
      WR_HI: begin
        mem_we   = 1'b1;
        mem_data = hold[2*BYTE_W-1:BYTE_W];
      end
      default: begin
        mem_we   = 1'b0;
        mem_data = '0;
      end
    endcase
  end

  assign res_ready = (state == ARMED);
  assign full      = (state == FULL);

endmodule
